// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexes one BCD-to-7-segment decoder across DIGITS common-anode digits.
// Latency: outputs registered from next-state values; a loaded frame appears at the next scan wrap (<= DIGITS*REFRESH_DIV cycles).
// Backpressure: ready drops after a load is accepted and rises again once that frame is committed; loads while !ready are ignored.
//
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   load, value_in      - frame request; value_in[3:0] is digit 0 (least significant)
//   ready               - a new frame can be accepted
//   digit_number        - BCD value of the digit in the current slot (decoder number input)
//   anode_n             - active-low digit enables, at most one bit low
//   frame_done          - one-cycle pulse following each scan wrap
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GHOST_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  output logic                  ready,
  output logic [3:0]            digit_number,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GHOST_END = PW'(GHOST_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]         prescaler_q, prescaler_d;
  logic [IW-1:0]         index_q, index_d;
  logic [4*DIGITS-1:0]   display_q, display_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  ready_q, ready_d;
  logic [3:0]            digit_number_q, digit_number_d;
  logic [DIGITS-1:0]     anode_n_q, anode_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  wrap;
  logic                  zero_run;

  always_comb begin
    tick = (prescaler_q == PRE_LAST);
    wrap = tick && (index_q == IDX_LAST);

    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    index_d     = index_q;
    if (tick) begin
      index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    end

    // Accept and commit are mutually exclusive: accept needs ready_q=1,
    // commit needs ready_q=0, so a load on the commit cycle is dropped.
    pending_d = pending_q;
    display_d = display_q;
    ready_d   = ready_q;
    if (load && ready_q) begin
      pending_d = value_in;
      ready_d   = 1'b0;
    end else if (wrap && !ready_q) begin
      display_d = pending_q;
      ready_d   = 1'b1;
    end

    frame_done_d = wrap;

    // Walk from the most significant digit down; zero_run stays set while
    // every digit seen so far is exactly zero. An invalid digit (>9) is
    // non-zero, so it ends the run for the digits below it.
    digit_number_d = '0;
    anode_n_d      = '1;
    zero_run       = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (display_d[k*4 +: 4] == 4'd0);
      if (index_d == IW'(k)) begin
        digit_number_d = display_d[k*4 +: 4];
        if ((prescaler_d >= GHOST_END) &&
            (display_d[k*4 +: 4] <= 4'd9) &&
            !((LZ_BLANK != 0) && (k != 0) && zero_run)) begin
          anode_n_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      index_q        <= '0;
      display_q      <= '0;
      pending_q      <= '0;
      ready_q        <= 1'b1;
      digit_number_q <= '0;
      anode_n_q      <= '1;
      frame_done_q   <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      index_q        <= index_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      ready_q        <= ready_d;
      digit_number_q <= digit_number_d;
      anode_n_q      <= anode_n_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign ready        = ready_q;
  assign digit_number = digit_number_q;
  assign anode_n      = anode_n_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: checks the scanner against a cycle-count based model of the display.
// Latency: model state is updated on the same clock edge as the DUT and compared on the falling edge.
// Backpressure: loads are issued only when the scenario calls for them; the model applies the accept/ignore rules.
module tb_seven_segment_scanner;

  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int ND    = 4;
  localparam int FRAME = RD * ND;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value_in;

  logic        ready, fd, ready2, fd2;
  logic [3:0]  dn, dn2, an, an2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: time is a plain cycle count since reset; slot and
  // prescaler are derived from it arithmetically.
  int          m_cyc;
  logic [15:0] m_disp, m_pend;
  logic        m_ready, m_fd;

  seven_segment_scanner #(.DIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .LZ_BLANK(1)) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in),
    .ready(ready), .digit_number(dn), .anode_n(an), .frame_done(fd)
  );

  seven_segment_scanner #(.DIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .LZ_BLANK(0)) dut_nlz (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in),
    .ready(ready2), .digit_number(dn2), .anode_n(an2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc   <= 0;
      m_disp  <= 16'h0;
      m_pend  <= 16'h0;
      m_ready <= 1'b1;
      m_fd    <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_fd  <= ((m_cyc % FRAME) == FRAME - 1);
      if (load && m_ready) begin
        m_pend  <= value_in;
        m_ready <= 1'b0;
      end else if (!m_ready && ((m_cyc % FRAME) == FRAME - 1)) begin
        m_disp  <= m_pend;
        m_ready <= 1'b1;
      end
    end
  end

  function automatic logic [3:0] exp_dn(input logic [15:0] d, input int cyc);
    logic [15:0] upper;
    upper = d >> (4 * ((cyc / RD) % ND));
    return upper[3:0];
  endfunction

  // A digit is lit after the ghost window if it is valid BCD and not a
  // leading zero (it and everything above it zero, except digit 0).
  function automatic logic [3:0] exp_an(input logic [15:0] d, input int cyc, input bit lz);
    int          pres, slot, dig;
    logic [15:0] upper;
    logic [3:0]  r;
    pres  = cyc % RD;
    slot  = (cyc / RD) % ND;
    upper = d >> (4 * slot);
    dig   = int'(upper & 16'hF);
    r     = 4'hF;
    if (pres >= GC && dig <= 9 && !(lz && slot != 0 && upper == 16'h0)) r[slot] = 1'b0;
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_tests += 4;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_anode got %b exp 1111", an); end
    if (dn !== 4'h0) begin n_fail++; $display("FAIL reset_digit got %h exp 0", dn); end
    if (fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", fd); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= RD; k++) begin
      logic [3:0] e;
      @(negedge clk);
      e = (k >= 2 && k <= 7) ? 4'b1110 : 4'b1111;
      n_tests += 2;
      if (an !== e) begin n_fail++; $display("FAIL reset_slot0_anode pres=%0d got %b exp %b", k % RD, an, e); end
      if (dn !== 4'h0) begin n_fail++; $display("FAIL reset_slot0_digit pres=%0d got %h exp 0", k % RD, dn); end
    end
  endtask

  task automatic test_load_commit();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    load     = 1'b1;
    value_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL lc_ready_drop got %b exp 0", ready); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      n_tests += 5;
      if (dn !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL lc_digit cyc=%0d got %h exp %h", m_cyc, dn, exp_dn(m_disp, m_cyc)); end
      if (dn2 !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL lc_digit_nlz cyc=%0d got %h exp %h", m_cyc, dn2, exp_dn(m_disp, m_cyc)); end
      if (an !== exp_an(m_disp, m_cyc, 1'b1)) begin n_fail++; $display("FAIL lc_anode cyc=%0d got %b exp %b", m_cyc, an, exp_an(m_disp, m_cyc, 1'b1)); end
      if (an2 !== exp_an(m_disp, m_cyc, 1'b0)) begin n_fail++; $display("FAIL lc_anode_nlz cyc=%0d got %b exp %b", m_cyc, an2, exp_an(m_disp, m_cyc, 1'b0)); end
      if (ready !== m_ready || fd !== m_fd || ready2 !== m_ready || fd2 !== m_fd) begin
        n_fail++; $display("FAIL lc_ready_fd cyc=%0d got %b%b exp %b%b", m_cyc, ready, fd, m_ready, m_fd);
      end
      if (m_cyc == FRAME) begin
        n_tests++;
        if (fd !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL lc_wrap got fd=%b ready=%b exp 1 1", fd, ready); end
      end
      if (m_cyc == FRAME + 4) begin
        n_tests++;
        if (dn !== 4'd4 || an !== 4'b1110) begin n_fail++; $display("FAIL lc_slot0 got %h/%b exp 4/1110", dn, an); end
      end
      if (m_cyc == FRAME + 3 * RD + 5) begin
        n_tests++;
        if (dn !== 4'd1 || an !== 4'b0111) begin n_fail++; $display("FAIL lc_slot3 got %h/%b exp 1/0111", dn, an); end
      end
    end
  endtask

  task automatic test_pattern(input logic [15:0] v, input string tag);
    for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL %s wait_ready got %b exp 1", tag, ready); end
    load     = 1'b1;
    value_in = v;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      n_tests += 5;
      if (dn !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL %s digit cyc=%0d got %h exp %h", tag, m_cyc, dn, exp_dn(m_disp, m_cyc)); end
      if (dn2 !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL %s digit_nlz cyc=%0d got %h exp %h", tag, m_cyc, dn2, exp_dn(m_disp, m_cyc)); end
      if (an !== exp_an(m_disp, m_cyc, 1'b1)) begin n_fail++; $display("FAIL %s anode cyc=%0d got %b exp %b", tag, m_cyc, an, exp_an(m_disp, m_cyc, 1'b1)); end
      if (an2 !== exp_an(m_disp, m_cyc, 1'b0)) begin n_fail++; $display("FAIL %s anode_nlz cyc=%0d got %b exp %b", tag, m_cyc, an2, exp_an(m_disp, m_cyc, 1'b0)); end
      if (ready !== m_ready || fd !== m_fd || ready2 !== m_ready || fd2 !== m_fd) begin
        n_fail++; $display("FAIL %s ready_fd cyc=%0d got %b%b exp %b%b", tag, m_cyc, ready, fd, m_ready, m_fd);
      end
    end
  endtask

  task automatic test_handshake();
    int fd_seen;
    for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
    load = 1'b1; value_in = 16'h1111;
    @(negedge clk);
    value_in = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    // phase 0: 1111 commits; phase 1: 5555 loaded then 6666 held across commit
    for (int phase = 0; phase < 3; phase++) begin
      fd_seen = 0;
      for (int i = 0; i < 2 * FRAME && fd_seen == 0; i++) begin
        @(negedge clk);
        n_tests += 5;
        if (dn !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL hs digit cyc=%0d got %h exp %h", m_cyc, dn, exp_dn(m_disp, m_cyc)); end
        if (dn2 !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL hs digit_nlz cyc=%0d got %h exp %h", m_cyc, dn2, exp_dn(m_disp, m_cyc)); end
        if (an !== exp_an(m_disp, m_cyc, 1'b1)) begin n_fail++; $display("FAIL hs anode cyc=%0d got %b exp %b", m_cyc, an, exp_an(m_disp, m_cyc, 1'b1)); end
        if (an2 !== exp_an(m_disp, m_cyc, 1'b0)) begin n_fail++; $display("FAIL hs anode_nlz cyc=%0d got %b exp %b", m_cyc, an2, exp_an(m_disp, m_cyc, 1'b0)); end
        if (ready !== m_ready || fd !== m_fd || ready2 !== m_ready || fd2 !== m_fd) begin
          n_fail++; $display("FAIL hs ready_fd cyc=%0d got %b%b exp %b%b", m_cyc, ready, fd, m_ready, m_fd);
        end
        if (fd === 1'b1) fd_seen = 1;
      end
      n_tests++;
      if (fd_seen == 0) begin n_fail++; $display("FAIL hs frame_done_timeout phase=%0d got 0 exp 1", phase); end
      if (phase == 0) begin
        n_tests++;
        if (dn !== 4'd1) begin n_fail++; $display("FAIL hs_first_wins got %h exp 1", dn); end
        load = 1'b1; value_in = 16'h5555;
        @(negedge clk);
        value_in = 16'h6666;
      end else if (phase == 1) begin
        n_tests += 2;
        if (dn !== 4'd5) begin n_fail++; $display("FAIL hs_commit_5555 got %h exp 5", dn); end
        if (ready !== 1'b1) begin n_fail++; $display("FAIL hs_commit_ready got %b exp 1", ready); end
        @(negedge clk);
        load = 1'b0;
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL hs_held_load_capture got ready=%b exp 0", ready); end
      end else begin
        n_tests++;
        if (dn !== 4'd6) begin n_fail++; $display("FAIL hs_commit_6666 got %h exp 6", dn); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hit;
    for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
    load = 1'b1; value_in = 16'h7777;
    @(negedge clk);
    load = 1'b0;
    hit = 0;
    for (int i = 0; i < 2 * FRAME && hit == 0; i++) begin
      @(negedge clk);
      if ((m_cyc % FRAME) == 2 * RD + 5) hit = 1;
    end
    n_tests += 2;
    if (hit == 0) begin n_fail++; $display("FAIL rm_align_timeout got 0 exp 1"); end
    if (an !== 4'b1011) begin n_fail++; $display("FAIL rm_before got %b exp 1011", an); end
    reset = 1'b1;
    #1;
    n_tests += 2;
    if (an !== 4'hF || an2 !== 4'hF) begin n_fail++; $display("FAIL rm_async_anode got %b/%b exp 1111", an, an2); end
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rm_async_ready got %b exp 1", ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      n_tests += 6;
      if (dn !== 4'h0) begin n_fail++; $display("FAIL rm_cleared cyc=%0d got %h exp 0", m_cyc, dn); end
      if (dn2 !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL rm digit_nlz cyc=%0d got %h exp %h", m_cyc, dn2, exp_dn(m_disp, m_cyc)); end
      if (an !== exp_an(m_disp, m_cyc, 1'b1)) begin n_fail++; $display("FAIL rm anode cyc=%0d got %b exp %b", m_cyc, an, exp_an(m_disp, m_cyc, 1'b1)); end
      if (an2 !== exp_an(m_disp, m_cyc, 1'b0)) begin n_fail++; $display("FAIL rm anode_nlz cyc=%0d got %b exp %b", m_cyc, an2, exp_an(m_disp, m_cyc, 1'b0)); end
      if (ready !== 1'b1) begin n_fail++; $display("FAIL rm_no_pending cyc=%0d got %b exp 1", m_cyc, ready); end
      if (fd !== m_fd || fd2 !== m_fd) begin n_fail++; $display("FAIL rm frame_done cyc=%0d got %b exp %b", m_cyc, fd, m_fd); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_tests += 5;
      if (dn !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL rnd digit cyc=%0d got %h exp %h", m_cyc, dn, exp_dn(m_disp, m_cyc)); end
      if (dn2 !== exp_dn(m_disp, m_cyc)) begin n_fail++; $display("FAIL rnd digit_nlz cyc=%0d got %h exp %h", m_cyc, dn2, exp_dn(m_disp, m_cyc)); end
      if (an !== exp_an(m_disp, m_cyc, 1'b1)) begin n_fail++; $display("FAIL rnd anode cyc=%0d got %b exp %b", m_cyc, an, exp_an(m_disp, m_cyc, 1'b1)); end
      if (an2 !== exp_an(m_disp, m_cyc, 1'b0)) begin n_fail++; $display("FAIL rnd anode_nlz cyc=%0d got %b exp %b", m_cyc, an2, exp_an(m_disp, m_cyc, 1'b0)); end
      if (ready !== m_ready || fd !== m_fd || ready2 !== m_ready || fd2 !== m_fd) begin
        n_fail++; $display("FAIL rnd ready_fd cyc=%0d got %b%b exp %b%b", m_cyc, ready, fd, m_ready, m_fd);
      end
      load = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < ND; d++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      value_in[d*4 +: 4] = 4'd0;
        else if (r < 9) value_in[d*4 +: 4] = 4'($urandom_range(0, 9));
        else            value_in[d*4 +: 4] = 4'($urandom_range(10, 15));
      end
    end
    load = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0;
    #2;
    reset = 1'b1;
    test_reset();
    test_load_commit();
    test_pattern(16'h0050, "lz_0050");
    test_pattern(16'h0000, "lz_0000");
    test_pattern(16'h1A03, "invalid_1A03");
    test_handshake();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
